tt_uio_bus_arbiter: RTL and testbench
=====================================

Name: tt_uio_bus_arbiter

Overview:
- Shares the 8 bidirectional uio pins of the test chip between N_REQ internal test sub-blocks.
- Grants ownership with round-robin fairness and a bounded hold time.
- Inserts a forced high-Z turnaround between owners so two drivers never overlap.
- Sits inside the top-level user project, between the test sub-blocks and the uio_out/uio_oe pads.

Parameters:
- N_REQ, 4, number of requesters (2..8); OWNER_W = clog2(N_REQ) is derived, not a parameter.
- MAX_HOLD, 16, OWN cycles after which a contended owner is preempted (>=2).
- TURNAROUND, 1, high-Z cycles between owners (>=1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock, synchronous, active-low
- ena  input  1  design-selected enable
- req  input  N_REQ  level request per requester; requester holds it high while it needs the bus
- req_out  input  8*N_REQ  per-requester pin data, requester k in bits [8k+7:8k]
- req_oe  input  8*N_REQ  per-requester output enables, same packing
- grant  output  N_REQ  one-hot ownership, registered
- owner_id  output  OWNER_W  index of current owner, valid only while busy=1
- busy  output  1  high in OWN
- uio_out  output  8  pad data
- uio_oe  output  8  pad enables (1 = drive)

Behaviour:
- Reset, sampled at posedge with rst_n=0:
  - state=IDLE; grant=0; owner_id=0; busy=0; hold counter=0; turnaround counter=0.
  - RR pointer set so requester 0 has highest priority.
  - Reset mid-OWN drops the grant and pad enables on that same edge; no turnaround is inserted.
- States: IDLE, OWN, TURN. No other states are reachable.
- Arbitration:
  - Happens in IDLE, and in the last TURN cycle.
  - Selects the first asserted req scanning from (last_owner+1) mod N_REQ upward with wrap.
  - Requires ena=1.
  - Winner is registered: grant/busy/owner_id rise at the next edge and state goes to OWN.
  - Latency req to grant from IDLE is 1 cycle.
- OWN:
  - uio_out = req_out[owner]; uio_oe = req_oe[owner]. This is a combinational mux from the registered owner, zero added latency.
  - Hold counter is 1 in the first OWN cycle and increments each cycle, saturating at MAX_HOLD.
- OWN exits to TURN at the next edge when any of the following holds:
  - req[owner]=0;
  - ena=0;
  - hold counter==MAX_HOLD and any other req=1 (preemption).
- OWN with no contention: the owner keeps the bus indefinitely; the counter stays at MAX_HOLD.
- Entering TURN:
  - grant=0, busy=0, uio_oe=0, uio_out=0.
  - last_owner is updated to the owner just released.
- TURN:
  - Lasts exactly TURNAROUND cycles.
  - In the last TURN cycle, arbitration runs: if a winner exists, go to OWN at the next edge, otherwise go to IDLE.
  - So owner-to-owner gap = TURNAROUND cycles of uio_oe=0.
- IDLE: uio_oe=0, uio_out=0.
- ena handling:
  - ena=0 blocks new grants in IDLE and TURN.
  - ena=0 in OWN forces exit to TURN.
- Preempted owner with req still high competes normally: it is lowest priority in the next arbitration.
- Simultaneous requests in the same cycle: resolved purely by the RR order from last_owner+1.
- A req deasserting in the same cycle a grant would be issued has no effect on that grant: the grant is based on the sampled req.
- Invariants:
  - At most one grant bit is set.
  - uio_oe is nonzero only in OWN.
  - grant, busy and owner_id never change except at clk edges.

Test Plan:
1. Reset then single requester: rst_n low 2 cycles, then req=4'b0100, req_out[23:16]=8'hA5, req_oe[23:16]=8'hFF.
   - Required: grant=4'b0100, owner_id=2, uio_out=8'hA5, uio_oe=8'hFF one cycle after req is sampled.
   - Drop req: the next cycle has grant=0 and uio_oe=0 for 1 cycle, then IDLE.
2. Simultaneous requests after reset: req=4'b1111 held, each owner releasing after 3 cycles.
   - Required grant order: 0,1,2,3,0.
   - Exactly 1 cycle of uio_oe=0 between owners.
3. Preemption: req=4'b0011 held continuously, MAX_HOLD=16.
   - Required: requester 0 owns 16 cycles, 1 turnaround cycle, requester 1 owns 16 cycles, then back to 0.
   - Repeat with req=4'b0001 only: ownership persists beyond 100 cycles.
4. ena drop mid-OWN: owner 1 active, ena=0 for 5 cycles.
   - Required: next edge goes to TURN, then IDLE with grant=0 throughout the low period.
   - Re-assert ena with req[1]=1: grant=4'b0010 one cycle later.
5. Reset mid-OWN: rst_n=0 for one edge while owner 3 drives uio_oe=8'h0F.
   - Required: that edge gives uio_oe=0, grant=0, busy=0.
   - After reset, with req=4'b1001, requester 0 wins.
6. TURNAROUND=3 build, req=4'b0110 with owner 1 releasing.
   - Required: exactly 3 cycles of uio_oe=0, then grant=4'b0100.
   - Assert no two grant bits are ever set in the same cycle.

Source files
------------

// File: rtl/tt_uio_bus_arbiter.sv
// Round-robin owner arbiter for the shared 8-bit uio pads.
// One requester at a time drives the pads. Each hand-over passes through a
// forced high-Z turnaround. A contended owner is preempted after MAX_HOLD
// cycles.
module tt_uio_bus_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned TURNAROUND = 1,
  localparam int unsigned OWNER_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ena_i,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [8*N_REQ-1:0]   req_out_i,
  input  logic [8*N_REQ-1:0]   req_oe_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic [OWNER_W-1:0]   owner_id_o,
  output logic                 busy_o,
  output logic [7:0]           uio_out_o,
  output logic [7:0]           uio_oe_o
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam int unsigned TurnW = $clog2(TURNAROUND + 1);

  typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] last_q, last_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [TurnW-1:0]   turn_q, turn_d;

  logic               win_valid;
  logic [OWNER_W-1:0] win_idx;
  logic               contend;
  logic               release_own;
  logic               turn_last;

  // Round-robin pick: first asserted req scanning upward from last_q + 1, with wrap.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      int unsigned idx;
      idx = (int'(last_q) + off) % N_REQ;
      if (!win_valid && req_i[idx]) begin
        win_valid = 1'b1;
        win_idx   = OWNER_W'(idx);
      end
    end
  end

  // Release conditions for the current owner.
  always_comb begin
    contend     = |(req_i & ~grant_q);
    release_own = !req_i[owner_q] || !ena_i ||
                  ((hold_q == HoldW'(MAX_HOLD)) && contend);
    turn_last   = (turn_q == TurnW'(TURNAROUND));
  end

  // Next-state logic: arbitration in IDLE and in the last TURN cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    unique case (state_q)
      StIdle: begin
        if (ena_i && win_valid) begin
          state_d = StOwn;
          grant_d = N_REQ'(1) << win_idx;
          owner_d = win_idx;
          hold_d  = HoldW'(1);
        end
      end
      StOwn: begin
        if (release_own) begin
          state_d = StTurn;
          grant_d = '0;
          last_d  = owner_q;
          hold_d  = '0;
          turn_d  = TurnW'(1);
        end else if (hold_q != HoldW'(MAX_HOLD)) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StTurn: begin
        if (turn_last) begin
          turn_d = '0;
          if (ena_i && win_valid) begin
            state_d = StOwn;
            grant_d = N_REQ'(1) << win_idx;
            owner_d = win_idx;
            hold_d  = HoldW'(1);
          end else begin
            state_d = StIdle;
          end
        end else begin
          turn_d = turn_q + TurnW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        hold_d  = '0;
        turn_d  = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset gives requester 0 top priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= OWNER_W'(N_REQ - 1);
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  // Pad mux driven from the registered owner; pads are high-Z outside OWN.
  always_comb begin
    uio_out_o = '0;
    uio_oe_o  = '0;
    if (state_q == StOwn) begin
      uio_out_o = req_out_i[8*int'(owner_q) +: 8];
      uio_oe_o  = req_oe_i[8*int'(owner_q) +: 8];
    end
  end

  assign grant_o    = grant_q;
  assign owner_id_o = owner_q;
  assign busy_o     = (state_q == StOwn);

endmodule

// File: tb/tb_tt_uio_bus_arbiter.sv
// Bench for tt_uio_bus_arbiter. Two instances share one stimulus:
// TURNAROUND=1 and TURNAROUND=3. An ownership/gap reference model checks
// every cycle. Directed steps cover the listed scenarios, then a randomized run follows.
module tb_tt_uio_bus_arbiter;

  localparam int N = 4;
  localparam int MAXH = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [N-1:0] req;
  logic [8*N-1:0] req_out;
  logic [8*N-1:0] req_oe;

  logic [N-1:0] grant0, grant1;
  logic [1:0]   owner0, owner1;
  logic         busy0, busy1;
  logic [7:0]   uout0, uout1, uoe0, uoe1;

  int tests = 0;
  int failed = 0;

  // Reference state per instance: owner (-1 = none), owned cycles, turnaround cycles left.
  int m_owner[2];
  int m_hold[2];
  int m_gap[2];
  int m_last[2];
  int ta_of[2];

  always #5 clk = ~clk;

  tt_uio_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH), .TURNAROUND(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .req_i(req), .req_out_i(req_out),
    .req_oe_i(req_oe), .grant_o(grant0), .owner_id_o(owner0), .busy_o(busy0),
    .uio_out_o(uout0), .uio_oe_o(uoe0)
  );

  tt_uio_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH), .TURNAROUND(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .ena_i(ena), .req_i(req), .req_out_i(req_out),
    .req_oe_i(req_oe), .grant_o(grant1), .owner_id_o(owner1), .busy_o(busy1),
    .uio_out_o(uout1), .uio_oe_o(uoe1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int d);
    for (int off = 1; off <= N; off++) begin
      int i;
      i = (m_last[d] + off) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int d);
    int others;
    if (!rst_n) begin
      m_owner[d] = -1; m_hold[d] = 0; m_gap[d] = 0; m_last[d] = N - 1;
    end else if (m_owner[d] >= 0) begin
      others = 0;
      for (int i = 0; i < N; i++) if (i != m_owner[d] && req[i]) others = 1;
      if (!req[m_owner[d]] || !ena || (m_hold[d] == MAXH && others == 1)) begin
        m_last[d] = m_owner[d]; m_owner[d] = -1; m_hold[d] = 0; m_gap[d] = ta_of[d];
      end else if (m_hold[d] < MAXH) begin
        m_hold[d]++;
      end
    end else if (m_gap[d] > 1) begin
      m_gap[d]--;
    end else begin
      int w;
      m_gap[d] = 0;
      w = ena ? pick(d) : -1;
      if (w >= 0) begin
        m_owner[d] = w; m_hold[d] = 1;
      end
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg [2];
    logic [7:0] eo [2], ee [2];
    for (int d = 0; d < 2; d++) begin
      eg[d] = '0; eo[d] = '0; ee[d] = '0;
      if (m_owner[d] >= 0) begin
        eg[d][m_owner[d]] = 1'b1;
        eo[d] = req_out[8*m_owner[d] +: 8];
        ee[d] = req_oe[8*m_owner[d] +: 8];
      end
    end
    chk("m0_grant", grant0, eg[0]);
    chk("m0_busy", busy0, m_owner[0] >= 0);
    chk("m0_uout", uout0, eo[0]);
    chk("m0_uoe", uoe0, ee[0]);
    if (m_owner[0] >= 0) chk("m0_owner", owner0, m_owner[0]);
    chk("m1_grant", grant1, eg[1]);
    chk("m1_busy", busy1, m_owner[1] >= 0);
    chk("m1_uout", uout1, eo[1]);
    chk("m1_uoe", uoe1, ee[1]);
    if (m_owner[1] >= 0) chk("m1_owner", owner1, m_owner[1]);
    chk("onehot0", $onehot0(grant0), 1'b1);
    chk("onehot1", $onehot0(grant1), 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n, gap, e;
    logic [N-1:0] prevg;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    ta_of[0] = 1; ta_of[1] = 3;
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_hold[d] = 0; m_gap[d] = 0; m_last[d] = N - 1;
    end
    rst_n = 1'b0; ena = 1'b1; req = '0; req_out = '0; req_oe = '0;

    // 1: reset two cycles, then a single requester.
    step();
    step();
    chk("rst_grant", grant0, 4'b0000);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_owner", owner0, 2'd0);
    chk("rst_oe", uoe0, 8'h00);
    rst_n = 1'b1;
    req = 4'b0100;
    req_out[23:16] = 8'hA5;
    req_oe[23:16] = 8'hFF;
    step();
    chk("t1_grant", grant0, 4'b0100);
    chk("t1_owner", owner0, 2'd2);
    chk("t1_uout", uout0, 8'hA5);
    chk("t1_uoe", uoe0, 8'hFF);
    req = 4'b0000;
    step();
    chk("t1_turn_grant", grant0, 4'b0000);
    chk("t1_turn_oe", uoe0, 8'h00);
    step();
    chk("t1_idle_busy", busy0, 1'b0);

    // 2: all four request; each owner releases after three owned cycles.
    do_reset();
    req = 4'hF;
    req_oe = '1;
    req_out = 32'h44332211;
    n = 0; gap = 0; prevg = '0;
    for (int it = 0; it < 60 && n < 5; it++) begin
      step();
      if (grant0 != '0 && prevg == '0) begin
        chk("t2_order", owner0, exp_order[n]);
        if (n > 0) chk("t2_gap", gap, 1);
        n++;
        gap = 0;
      end else if (grant0 == '0) begin
        gap++;
      end
      prevg = grant0;
      req = 4'hF;
      if (m_owner[0] >= 0 && m_hold[0] == 3) req[m_owner[0]] = 1'b0;
    end
    chk("t2_count", n, 5);

    // 3: preemption between two persistent requesters.
    do_reset();
    req = 4'b0011;
    for (int i = 1; i <= 35; i++) begin
      step();
      if (i <= 16) e = 1;
      else if (i == 17) e = 0;
      else if (i <= 33) e = 2;
      else if (i == 34) e = 0;
      else e = 1;
      chk("t3_sched", grant0, e);
    end
    // A lone requester is never preempted.
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 120; i++) begin
      step();
      chk("t3_solo", grant0, 4'b0001);
    end

    // 4: ena dropped while requester 1 owns the bus.
    do_reset();
    req = 4'b0010;
    step();
    step();
    chk("t4_own", grant0, 4'b0010);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_ena_low", grant0, 4'b0000);
    end
    ena = 1'b1;
    step();
    chk("t4_regrant", grant0, 4'b0010);

    // 5: reset while requester 3 drives the pads.
    do_reset();
    req = 4'b1000;
    req_oe = '0;
    req_oe[31:24] = 8'h0F;
    step();
    step();
    chk("t5_oe", uoe0, 8'h0F);
    rst_n = 1'b0;
    step();
    chk("t5_rst_oe", uoe0, 8'h00);
    chk("t5_rst_grant", grant0, 4'b0000);
    chk("t5_rst_busy", busy0, 1'b0);
    rst_n = 1'b1;
    req = 4'b1001;
    step();
    chk("t5_win0", grant0, 4'b0001);
    chk("t5_win1", grant1, 4'b0001);

    // 6: three-cycle turnaround instance, owner 1 hands over to requester 2.
    do_reset();
    req = 4'b0010;
    req_oe = '1;
    step();
    step();
    chk("t6_own", grant1, 4'b0010);
    req = 4'b0110;
    step();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_gap_oe", uoe1, 8'h00);
      chk("t6_gap_grant", grant1, 4'b0000);
    end
    step();
    chk("t6_next", grant1, 4'b0100);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      ena = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      req_out = $urandom;
      req_oe = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
